// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format defaults and FSM state encodings
// for both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BIT_TICKS = 10416;   // 100 MHz / 9600 baud
    localparam int UART_TMR_WIDTH = 14;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a delay flop
// that flags the falling edge of the synchronized signal.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_async,
    output logic sample,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Flops reset to the idle-high line level so reset release never looks like a start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p0 <= rx_async;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign sample = sync_p1;
    assign fall   = sync_p2 & ~sync_p1;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, and a hold-until-read
// output register with framing-error pulse and sticky overrun flag.
module uart_receive
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int TMR_WIDTH = UART_TMR_WIDTH,
    parameter int BIT_TICKS = UART_BIT_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(BIT_TICKS - 1);
    localparam logic [TMR_WIDTH-1:0] TMR_HALF = TMR_WIDTH'(BIT_TICKS >> 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic sample;
    logic fall;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .rx_async (uart_rx),
        .sample   (sample),
        .fall     (fall)
    );

    rx_state_t              state, state_nxt;
    logic [TMR_WIDTH-1:0]   tmr, tmr_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [DATA_BITS-1:0]   shreg, shreg_nxt;
    logic                   deliver;
    logic                   stop_bad;

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        deliver   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            RX_IDLE: begin
                tmr_nxt = '0;
                idx_nxt = '0;
                if (fall) state_nxt = RX_START;
            end
            RX_START: begin
                // A line back high at mid start bit was only a glitch
                if (tmr == TMR_HALF) begin
                    tmr_nxt   = '0;
                    state_nxt = sample ? RX_IDLE : RX_DATA;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            RX_DATA: begin
                if (tmr == TMR_LAST) begin
                    tmr_nxt        = '0;
                    shreg_nxt[idx] = sample;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        state_nxt = RX_STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            RX_STOP: begin
                // Return to IDLE mid stop bit so the next start edge can be caught
                if (tmr == TMR_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = RX_IDLE;
                    deliver   = sample;
                    stop_bad  = ~sample;
                end else begin
                    tmr_nxt = tmr + 1'b1;
                end
            end
            default: begin
                state_nxt = RX_IDLE;
                tmr_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RX_IDLE;
            tmr   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
        end
    end

    // Output holding register; a read in the delivery cycle frees the slot for the new byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (deliver) begin
                if (!valid || rd) begin
                    data  <= shreg;
                    valid <= 1'b1;
                    if (rd) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule
